data_ram_responder: RTL
=======================

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of word count (4096 x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait states per access (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port addr  input  32  byte address from the load/store interface.
REQ-006 SHALL have port w_data  input  32  lane-aligned write data.
REQ-007 SHALL have port wen  input  4  byte-lane write enables; bit i covers w_data[8i+7:8i].
REQ-008 SHALL have port ren  input  1  read request.
REQ-009 SHALL have port r_data  output  32  full-word read data, lane extraction done by the initiator.
REQ-010 SHALL have port ready  output  1  request accepted this cycle when high together with a request.
REQ-011 SHALL have port rvalid  output  1  one-cycle pulse, r_data valid for a read.
REQ-012 SHALL have port done  output  1  one-cycle pulse, access (read or write) complete.
REQ-013 SHALL have port err  output  1  out-of-range pulse, present only under the macro in REQ-032.

Function
REQ-014 SHALL define req = ren | (|wen).
REQ-015 SHALL implement states IDLE, WAIT, RESP; ready = 1 only in IDLE with rst_n high.
REQ-016 SHALL accept on a rising edge where state is IDLE and req is 1; non-IDLE requests are ignored, and the initiator holds them until ready.
REQ-017 SHALL take the word index from addr[DEPTH_LOG2+1:2]; addr[1:0] is ignored.
REQ-018 SHALL, at the accept edge, write only byte lanes with wen[i]=1; other lanes keep their contents.
REQ-019 SHALL, at the accept edge with ren=1, capture the pre-write word into a read holding register (read-before-write when ren and wen are both active).
REQ-020 SHALL, on accept, load a 4-bit wait counter with WAIT_CYCLES and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the cycle the counter reads 1.
REQ-022 SHALL, in RESP, assert done=1 for one cycle, set rvalid=1 if the accepted access included a read, drive r_data from the holding register, then return to IDLE.
REQ-023 SHALL give accept-to-done latency of WAIT_CYCLES+1 cycles, with back-to-back accepts every WAIT_CYCLES+2 cycles.
REQ-024 SHALL hold r_data stable after a read response until the next read response; write-only accesses do not change r_data.
REQ-025 SHALL keep done and rvalid low in IDLE and WAIT.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set state=IDLE, counter=0, r_data=0, rvalid=0, done=0, err=0.
REQ-027 SHALL keep ready=0 during any cycle where rst_n=0.
REQ-028 SHALL, on reset mid-access (WAIT or RESP), abort with no done/rvalid pulse; a write committed at accept stays committed.
REQ-029 SHALL not reset memory array contents.

Configuration
REQ-030 SHALL, without the macro, ignore addr[31:DEPTH_LOG2+2], so addresses wrap modulo the array size.
REQ-031 SHALL, without the macro, tie err to 0.
REQ-032 SHALL, with RAM_BOUNDS_CHECK_EN defined, flag an accepted access as out-of-range when addr[31:DEPTH_LOG2+2] != 0.
REQ-033 SHALL, under RAM_BOUNDS_CHECK_EN, suppress the write of an out-of-range access and return read data 0.
REQ-034 SHALL, under RAM_BOUNDS_CHECK_EN, pulse err in RESP together with done for an out-of-range access; timing is unchanged.

Verification
REQ-035 SHALL check a full-word write then read: WAIT_CYCLES=1, wen=4'b1111, addr=0x10, w_data=0xDEADBEEF, then ren at 0x10 -> done 2 cycles after each accept, with r_data=0xDEADBEEF and rvalid pulsing once.
REQ-036 SHALL check a byte-lane write: preload 0x11223344 at 0x20, then wen=4'b0100, w_data=0x00AB0000 -> read returns 0x11AB3344.
REQ-037 SHALL check simultaneous read and write: word 0x30=0xAAAAAAAA, then ren=1 and wen=4'b1111 with w_data=0x55555555 -> r_data=0xAAAAAAAA, and a later read returns 0x55555555.
REQ-038 SHALL check zero wait states: WAIT_CYCLES=0 with continuous reads -> ready alternates 1/0, and done follows each accept by 1 cycle.
REQ-039 SHALL check reset mid-access: rst_n=0 while in WAIT (WAIT_CYCLES=3) -> no done, r_data=0, and ready=1 the first cycle after rst_n returns high.
REQ-040 SHALL check wrap versus bounds checking: write to addr=0x00004010 with DEPTH_LOG2=12 -> without the macro, word 0x10 is updated; with RAM_BOUNDS_CHECK_EN, err=1, word 0x10 is unchanged, and a read there returns 0.

Source files
------------

// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
//
// Single-port word RAM with a byte-lane write interface and a small
// request/response handshake for a load/store unit. A request (read, write or
// both) is accepted in IDLE when ready is high. The write lanes are committed
// at the accept edge. For a read, the pre-write word is captured at the same
// edge. After WAIT_CYCLES wait states the block spends one RESP cycle. In that
// cycle it pulses done, and also rvalid for reads, and presents the read word
// on r_data.
//
// Parameters
//   DEPTH_LOG2   log2 of the number of 32-bit words (default 4096 words)
//   WAIT_CYCLES  extra wait states per access, 0..15
//
// Ports
//   clk     in   1   clock, rising edge
//   rst_n   in   1   synchronous active-low reset
//   addr    in   32  byte address; word index is addr[DEPTH_LOG2+1:2]
//   w_data  in   32  lane-aligned write data
//   wen     in   4   byte-lane write enables
//   ren     in   1   read request
//   r_data  out  32  full-word read data, held until the next read response
//   ready   out  1   request accepted this cycle when high with a request
//   rvalid  out  1   one-cycle pulse, r_data valid for a read
//   done    out  1   one-cycle pulse, access complete
//   err     out  1   out-of-range pulse alongside done
//
// Optional feature
//   RAM_BOUNDS_CHECK_EN  When defined, an access with non-zero address bits
//                        above the array is flagged. Its write is dropped,
//                        its read returns 0, and err pulses with done. When
//                        not defined, the upper address bits are ignored
//                        (addresses wrap) and err is tied low.
// -----------------------------------------------------------------------------
module data_ram_responder #(
   parameter int DEPTH_LOG2  = 12,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] w_data,
   input  logic [3:0]  wen,
   input  logic        ren,
   output logic [31:0] r_data,
   output logic        ready,
   output logic        rvalid,
   output logic        done,
   output logic        err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;

   logic [31:0]           mem [DEPTH];
   logic [3:0]            wait_cnt;
   logic [31:0]           hold;
   logic                  is_read;
   logic                  oor_q;
   logic                  err_q;
   logic                  req;
   logic                  accept;
   logic                  oor;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           rd_word;

   assign req    = ren | (|wen);
   assign ready  = (state == IDLE) && rst_n;
   assign accept = (state == IDLE) && req;
   assign idx    = addr[DEPTH_LOG2+1:2];

`ifdef RAM_BOUNDS_CHECK_EN
   assign oor = (addr[31:DEPTH_LOG2+2] != '0);
   assign err = err_q;
`else
   assign oor = 1'b0;
   assign err = 1'b0;
`endif

   // An out-of-range read returns zero instead of the aliased word.
   assign rd_word = oor ? 32'd0 : mem[idx];

   // Without bounds checking, the byte offset, the upper address bits and the
   // error register are intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0], err_q};

   // Memory array: the selected byte lanes are written at the accept edge. The
   // array has no reset, so contents survive rst_n. Reset gates this write
   // because ready is low during reset.
   always_ff @(posedge clk) begin
      if (rst_n && accept && !oor) begin
         for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
               mem[idx][8*i +: 8] <= w_data[8*i +: 8];
            end
         end
      end
   end

   // Handshake FSM. done, rvalid, err and r_data are registers. They are
   // loaded on the edge that enters RESP, so they are visible during the RESP
   // cycle, and they return low on the edge that leaves it. The read word is
   // sampled from the array before this edge's write takes effect, which gives
   // read-before-write for a combined access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         hold     <= 32'd0;
         is_read  <= 1'b0;
         oor_q    <= 1'b0;
         err_q    <= 1'b0;
         r_data   <= 32'd0;
         rvalid   <= 1'b0;
         done     <= 1'b0;
      end else begin
         done   <= 1'b0;
         rvalid <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  is_read  <= ren;
                  oor_q    <= oor;
                  wait_cnt <= WAIT_INIT;
                  if (ren) begin
                     hold <= rd_word;
                  end
                  if (WAIT_INIT == 4'd0) begin
                     // With no wait states, the response is issued straight from
                     // the array word instead of from hold.
                     state  <= RESP;
                     done   <= 1'b1;
                     rvalid <= ren;
                     err_q  <= oor;
                     if (ren) begin
                        r_data <= rd_word;
                     end
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt <= 4'd1) begin
                  state  <= RESP;
                  done   <= 1'b1;
                  rvalid <= is_read;
                  err_q  <= oor_q;
                  if (is_read) begin
                     r_data <= hold;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
